prog_mem_ctrl: RTL and testbench

// - Owns the CPU's 16x8 program memory and sequences the CPU: clear, load, run, halt.
// - Replaces the fixed ROM: a loader writes the program through a valid/ready handshake.
// - While loading, the CPU is held in reset. While running, the CPU fetches through this block.
// - Halting (by request or breakpoint) serves the CPU a self-jump {JMP_OPC, address}, so the CPU spins in place.

---
 rtl/prog_mem_ctrl.sv | 152 +++++++++++++++
 tb/tb_prog_mem_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : prog_mem_ctrl
// Description : Loadable 16x8 program memory that sequences a small CPU
//               through clear, load, run and halt, with breakpoint support.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_mem_ctrl #(
    parameter int                         ADDR_W  = 4,
    parameter int                         DATA_W  = 8,
    parameter logic [DATA_W-ADDR_W-1:0]   JMP_OPC = 4'b1111,
    parameter int                         CNT_W   = 16
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic [ADDR_W-1:0] cpu_address,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_n_reset,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    output logic [2:0]        state,
    output logic [DATA_W-1:0] checksum,
    output logic [CNT_W-1:0]  fetch_count
);

    localparam int                c_DEPTH   = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] c_PTR_MAX = '1;
    localparam logic [CNT_W-1:0]  c_CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic [DATA_W-1:0]   r_mem [c_DEPTH];
    logic                r_ld_ready;
    logic                r_ld_done;
    logic [DATA_W-1:0]   r_checksum;
    logic [CNT_W-1:0]    r_fetch_count;
    logic                r_bp_mask;
    logic                r_cpu_n_reset;
    logic                w_accept;
    logic                w_bp_hit;

    assign w_accept = r_ld_ready & ld_valid;
    assign w_bp_hit = (r_state == S_RUN) & bp_en & (cpu_address == bp_addr) & ~r_bp_mask;

    // Outside an un-broken RUN cycle the CPU is fed a jump to its own address.
    assign cpu_dout    = ((r_state == S_RUN) && !w_bp_hit) ? r_mem[cpu_address]
                                                           : {JMP_OPC, cpu_address};
    assign cpu_n_reset = r_cpu_n_reset;
    assign ld_ready    = r_ld_ready;
    assign ld_done     = r_ld_done;
    assign state       = r_state;
    assign checksum    = r_checksum;
    assign fetch_count = r_fetch_count;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_CLEAR: if (r_ptr == c_PTR_MAX) w_next_state = S_IDLE;
            S_IDLE: begin
                if (ld_start)     w_next_state = S_LOAD;
                else if (run_req) w_next_state = S_RUN;
            end
            // LOAD lingers one cycle with ld_ready low while ld_done pulses.
            S_LOAD:  if (r_ld_done) w_next_state = S_IDLE;
            S_RUN:   if (halt_req || w_bp_hit) w_next_state = S_HALT;
            S_HALT: begin
                if (ld_start)     w_next_state = S_LOAD;
                else if (run_req) w_next_state = S_RUN;
            end
            default: w_next_state = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state       <= S_CLEAR;
            r_ptr         <= '0;
            r_ld_ready    <= 1'b0;
            r_ld_done     <= 1'b0;
            r_checksum    <= '0;
            r_fetch_count <= '0;
            r_bp_mask     <= 1'b0;
            r_cpu_n_reset <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_ld_done     <= 1'b0;
            r_cpu_n_reset <= (w_next_state == S_RUN) || (w_next_state == S_HALT);
            case (r_state)
                S_CLEAR: r_ptr <= r_ptr + ADDR_W'(1);
                S_IDLE: begin
                    if (ld_start) begin
                        r_ptr      <= '0;
                        r_checksum <= '0;
                        r_ld_ready <= 1'b1;
                    end else if (run_req) begin
                        r_fetch_count <= '0;
                        r_bp_mask     <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_ptr      <= r_ptr + ADDR_W'(1);
                        r_checksum <= r_checksum + ld_data;
                        if (r_ptr == c_PTR_MAX) begin
                            r_ld_ready <= 1'b0;
                            r_ld_done  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (r_fetch_count != c_CNT_MAX) r_fetch_count <= r_fetch_count + CNT_W'(1);
                    if (cpu_address != bp_addr)     r_bp_mask     <= 1'b0;
                end
                S_HALT: begin
                    if (ld_start) begin
                        r_ptr      <= '0;
                        r_checksum <= '0;
                        r_ld_ready <= 1'b1;
                    end else if (run_req) begin
                        // Resuming from a breakpoint must not re-trigger it immediately.
                        r_bp_mask <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) r_mem[r_ptr] <= '0;
        else if (w_accept)      r_mem[r_ptr] <= ld_data;
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_prog_mem_ctrl
// Description : Self-checking bench for prog_mem_ctrl using a memory/checksum
//               reference model and randomized program bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_mem_ctrl;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              n_reset = 1'b0;
    logic [ADDR_W-1:0] cpu_address = '0;
    logic [DATA_W-1:0] cpu_dout;
    logic              cpu_n_reset;
    logic              ld_start = 1'b0;
    logic              ld_valid = 1'b0;
    logic [DATA_W-1:0] ld_data = '0;
    logic              ld_ready;
    logic              ld_done;
    logic              run_req = 1'b0;
    logic              halt_req = 1'b0;
    logic              bp_en = 1'b0;
    logic [ADDR_W-1:0] bp_addr = '0;
    logic [2:0]        state;
    logic [DATA_W-1:0] checksum;
    logic [CNT_W-1:0]  fetch_count;

    logic [DATA_W-1:0] prog      [16];
    logic [DATA_W-1:0] model_mem [16];
    int                model_fetch;
    int                n_checks = 0;
    int                n_fail   = 0;

    prog_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .JMP_OPC(4'b1111), .CNT_W(CNT_W)) dut (
        .clk(clk), .n_reset(n_reset), .cpu_address(cpu_address), .cpu_dout(cpu_dout),
        .cpu_n_reset(cpu_n_reset), .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_done(ld_done), .run_req(run_req), .halt_req(halt_req),
        .bp_en(bp_en), .bp_addr(bp_addr), .state(state), .checksum(checksum),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] sum_of(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(prog[i]);
        return 8'(s % 256);
    endfunction

    task automatic wait_clear(output int cnt);
        cnt = 0;
        while (state == 3'd1 && cnt < 40) begin
            cnt++;
            cyc();
        end
    endtask

    // Offers prog[0..n-1] on the loader port; stops after n accepted bytes.
    task automatic load_prog(input int n, input bit gaps, output int acc, output int dones);
        int k = 0;
        acc   = 0;
        dones = 0;
        while (acc < n && k < 200) begin
            ld_valid = gaps ? (k % 2 == 0) : 1'b1;
            ld_data  = prog[acc];
            if (ld_valid && ld_ready) acc++;
            cyc();
            k++;
            if (ld_done) dones++;
        end
        ld_valid = 1'b0;
    endtask

    initial begin
        int acc, dones, cnt;
        logic [3:0] a;

        // Reset state and clear sequence
        repeat (3) cyc();
        check("rst_state", state, 1);
        check("rst_cpu_n_reset", cpu_n_reset, 0);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_ld_done", ld_done, 0);
        check("rst_checksum", checksum, 0);
        check("rst_fetch", fetch_count, 0);
        n_reset = 1'b1;
        wait_clear(cnt);
        check("clear_len", cnt, 16);
        check("idle_after_clear", state, 0);
        for (int i = 0; i < 16; i++) model_mem[i] = '0;

        cpu_address = 4'h7;
        #1 check("idle_dout", cpu_dout, 8'hF7);

        // Run the cleared memory: every fetch returns 0x00
        run_req = 1'b1; cyc(); run_req = 1'b0;
        model_fetch = 0;
        check("run_state", state, 3);
        check("run_cpu_n_reset", cpu_n_reset, 1);
        for (int i = 0; i < 16; i++) begin
            cpu_address = i[3:0];
            #1 check("zero_dout", cpu_dout, model_mem[i]);
            cyc(); model_fetch++;
        end
        halt_req = 1'b1; cyc(); halt_req = 1'b0; model_fetch++;
        check("halt_state", state, 4);
        check("fetch_zero_run", fetch_count, model_fetch);

        // Gapped load of 0x00..0x0F from HALT
        for (int i = 0; i < 16; i++) prog[i] = 8'(i);
        ld_start = 1'b1; cyc(); ld_start = 1'b0;
        check("load_state", state, 2);
        check("load_ready", ld_ready, 1);
        check("load_cpu_reset", cpu_n_reset, 0);
        load_prog(16, 1'b1, acc, dones);
        check("gap_accepted", acc, 16);
        check("gap_ready_low", ld_ready, 0);
        check("gap_checksum", checksum, sum_of(16));
        check("gap_checksum_lit", checksum, 8'h78);
        cyc();
        if (ld_done) dones++;
        check("gap_done_pulses", dones, 1);
        check("gap_idle", state, 0);
        for (int i = 0; i < 16; i++) model_mem[i] = prog[i];

        // Random program; run/halt/ld_start held during LOAD must be ignored
        for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
        ld_start = 1'b1; cyc(); ld_start = 1'b0;
        run_req = 1'b1; halt_req = 1'b1; ld_start = 1'b1;
        load_prog(16, 1'b0, acc, dones);
        run_req = 1'b0; halt_req = 1'b0; ld_start = 1'b0;
        check("rnd_accepted", acc, 16);
        check("rnd_checksum", checksum, sum_of(16));
        check("rnd_still_load", state, 2);
        cyc();
        check("rnd_idle", state, 0);
        for (int i = 0; i < 16; i++) model_mem[i] = prog[i];

        // Halt on the 5th RUN cycle
        run_req = 1'b1; cyc(); run_req = 1'b0;
        model_fetch = 0;
        for (int i = 1; i <= 5; i++) begin
            a = 4'($urandom);
            cpu_address = a;
            #1 check("run_dout", cpu_dout, model_mem[a]);
            if (i == 5) halt_req = 1'b1;
            cyc(); model_fetch++;
        end
        halt_req = 1'b0;
        check("halt5_state", state, 4);
        check("halt5_fetch", fetch_count, model_fetch);
        a = 4'($urandom);
        cpu_address = a;
        #1 check("halt_dout", cpu_dout, {4'hF, a});
        repeat (3) cyc();
        check("halt_fetch_frozen", fetch_count, 5);
        check("halt_cpu_n_reset", cpu_n_reset, 1);

        // Breakpoint at address 3 on a fresh program
        ld_start = 1'b1; cyc(); ld_start = 1'b0;
        check("halt_to_load_reset", cpu_n_reset, 0);
        for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
        load_prog(16, 1'b0, acc, dones);
        cyc();
        for (int i = 0; i < 16; i++) model_mem[i] = prog[i];
        bp_en = 1'b1; bp_addr = 4'd3;
        run_req = 1'b1; cyc(); run_req = 1'b0;
        model_fetch = 0;
        for (int i = 0; i < 3; i++) begin
            cpu_address = i[3:0];
            #1 check("bp_pre_dout", cpu_dout, model_mem[i]);
            cyc(); model_fetch++;
        end
        cpu_address = 4'd3;
        #1 check("bp_hit_dout", cpu_dout, 8'hF3);
        cyc(); model_fetch++;
        check("bp_halt", state, 4);
        check("bp_halt_dout", cpu_dout, 8'hF3);
        run_req = 1'b1; cyc(); run_req = 1'b0;
        check("bp_resume_dout", cpu_dout, model_mem[3]);
        cyc(); model_fetch++;
        check("bp_resume_run", state, 3);
        cpu_address = 4'd4;
        #1 check("bp_next_dout", cpu_dout, model_mem[4]);
        cyc(); model_fetch++;
        check("bp_no_rehalt", state, 3);
        check("bp_fetch", fetch_count, model_fetch);
        cpu_address = 4'd3;
        #1 check("bp_rehit_dout", cpu_dout, 8'hF3);
        cyc();
        check("bp_rehit_halt", state, 4);

        // RUN ignores ld_start; halt_req beats run_req
        bp_en = 1'b0; cpu_address = 4'd5;
        run_req = 1'b1; cyc(); run_req = 1'b0;
        ld_start = 1'b1; cyc(); ld_start = 1'b0;
        check("run_ignores_ld_start", state, 3);
        halt_req = 1'b1; run_req = 1'b1; cyc(); halt_req = 1'b0; run_req = 1'b0;
        check("halt_beats_run", state, 4);

        // Reset in the middle of a load
        ld_start = 1'b1; cyc(); ld_start = 1'b0;
        for (int i = 0; i < 16; i++) prog[i] = 8'($urandom_range(1, 255));
        load_prog(7, 1'b0, acc, dones);
        check("part_accepted", acc, 7);
        check("part_checksum", checksum, sum_of(7));
        #2 n_reset = 1'b0;
        #1;
        check("mid_rst_cpu_reset", cpu_n_reset, 0);
        check("mid_rst_ready", ld_ready, 0);
        check("mid_rst_checksum", checksum, 0);
        check("mid_rst_state", state, 1);
        cyc();
        n_reset = 1'b1;
        wait_clear(cnt);
        check("reclear_len", cnt, 16);
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        run_req = 1'b1; cyc(); run_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cpu_address = i[3:0];
            #1 check("reclear_dout", cpu_dout, model_mem[i]);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
